// File: rtl/dpram_port_arbiter.sv
// Two-master arbiter in front of a 1W/1R dual-port RAM with registered read data.
// Write and read ports are arbitrated independently, each with its own round-robin pointer.
module dpram_port_arbiter #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          ram_wr,
    output logic [AW-1:0] ram_w_addr,
    output logic [DW-1:0] ram_din,
    output logic [AW-1:0] ram_r_addr,
    input  logic [DW-1:0] ram_dout
);

    logic          wReq0, wReq1, rReq0, rReq1;
    logic          wGnt0, wGnt1, rGnt0, rGnt1;
    logic          wPtr_q, wPtr_d;
    logic          rPtr_q, rPtr_d;
    logic [AW-1:0] rAddr_q, rAddr_d;
    logic          rdPend_q, rdId_q;
    logic          rValid0_q, rValid1_q;
    logic [DW-1:0] rData0_q, rData1_q;

    // Pointer value 0 favours m0; it flips only when both masters contend for the same port.
    always_comb begin
        wReq0 = m0_req & m0_we;
        wReq1 = m1_req & m1_we;
        rReq0 = m0_req & ~m0_we;
        rReq1 = m1_req & ~m1_we;

        wGnt0 = ~rst & wReq0 & (~wReq1 | ~wPtr_q);
        wGnt1 = ~rst & wReq1 & (~wReq0 | wPtr_q);
        rGnt0 = ~rst & rReq0 & (~rReq1 | ~rPtr_q);
        rGnt1 = ~rst & rReq1 & (~rReq0 | rPtr_q);

        wPtr_d = (wReq0 & wReq1) ? ~wPtr_q : wPtr_q;
        rPtr_d = (rReq0 & rReq1) ? ~rPtr_q : rPtr_q;

        m0_gnt = wGnt0 | rGnt0;
        m1_gnt = wGnt1 | rGnt1;

        ram_wr     = wGnt0 | wGnt1;
        ram_w_addr = '0;
        ram_din    = '0;
        if (wGnt0) begin
            ram_w_addr = m0_addr;
            ram_din    = m0_wdata;
        end else if (wGnt1) begin
            ram_w_addr = m1_addr;
            ram_din    = m1_wdata;
        end

        rAddr_d = rAddr_q;
        if (rGnt0) begin
            rAddr_d = m0_addr;
        end else if (rGnt1) begin
            rAddr_d = m1_addr;
        end
        ram_r_addr = rst ? '0 : rAddr_d;

        // Registered read results are masked while rst is high so nothing leaks out before the flush edge.
        m0_rvalid = rValid0_q & ~rst;
        m1_rvalid = rValid1_q & ~rst;
        m0_rdata  = rst ? '0 : rData0_q;
        m1_rdata  = rst ? '0 : rData1_q;
    end

    // Stage 1 remembers who owns the read issued this cycle; stage 2 steers the RAM output back.
    always_ff @(posedge clk) begin
        if (rst) begin
            wPtr_q    <= 1'b0;
            rPtr_q    <= 1'b0;
            rAddr_q   <= '0;
            rdPend_q  <= 1'b0;
            rdId_q    <= 1'b0;
            rValid0_q <= 1'b0;
            rValid1_q <= 1'b0;
            rData0_q  <= '0;
            rData1_q  <= '0;
        end else begin
            wPtr_q    <= wPtr_d;
            rPtr_q    <= rPtr_d;
            rAddr_q   <= rAddr_d;
            rdPend_q  <= rGnt0 | rGnt1;
            rdId_q    <= rGnt1;
            rValid0_q <= rdPend_q & ~rdId_q;
            rValid1_q <= rdPend_q & rdId_q;
            if (rdPend_q && !rdId_q) begin
                rData0_q <= ram_dout;
            end
            if (rdPend_q && rdId_q) begin
                rData1_q <= ram_dout;
            end
        end
    end

endmodule

// File: doc/dpram_port_arbiter.md
Name: dpram_port_arbiter

Overview:
- Shares one dual-port RAM (1 write port, 1 registered read port, 256x16) between two requesters, m0 and m1.
- Arbitrates writes and reads independently, each with its own round-robin pointer.
- Drives the RAM port signals and routes returned read data to the requester that issued the read.
- Sits between the two requester blocks and the RAM instance.

Parameters:
AW, 8, address width (RAM depth 2**AW)
DW, 16, data width

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high; also routed to the RAM by the parent
m0_req  input  1  m0 request valid; held until granted
m0_we  input  1  1 = write, 0 = read; stable while m0_req high
m0_addr  input  AW  m0 address
m0_wdata  input  DW  m0 write data
m0_gnt  output  1  request accepted this cycle
m0_rvalid  output  1  m0_rdata valid, one-cycle pulse
m0_rdata  output  DW  read data returned to m0
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: as m0, for m1
ram_wr  output  1  RAM write enable
ram_w_addr  output  AW  RAM write address
ram_din  output  DW  RAM write data
ram_r_addr  output  AW  RAM read address
ram_dout  input  DW  RAM registered read data, valid the cycle after ram_r_addr is presented

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - While rst is high: all gnt = 0, all rvalid = 0, all rdata = 0, ram_wr = 0, ram_w_addr/ram_din/ram_r_addr = 0.
  - Both pointers reset to favour m0. Read pipeline is flushed.
- Request classes: wreq_i = mi_req & mi_we; rreq_i = mi_req & ~mi_we.
- Write port arbitration (combinational, same cycle):
  - If exactly one wreq is high, grant it.
  - If both are high, grant the master selected by wptr; wptr then toggles to point at the other master.
  - wptr changes only on a contended grant.
  - Granted master: gnt = 1, ram_wr = 1, ram_w_addr/ram_din = its addr/wdata.
  - No write granted: ram_wr = 0, ram_w_addr = 0, ram_din = 0.
- Read port arbitration: identical scheme with its own rptr.
  - Granted master: ram_r_addr = its addr.
  - No read granted: ram_r_addr holds its last value (harmless).
- Concurrency:
  - A write from one master and a read from the other are both granted in the same cycle.
  - Each master has at most one request per cycle, so it never gets both ports at once.
  - Non-granted requesters keep req high; no timeout.
- Read return pipeline:
  - Edge N (grant cycle): stage-1 flops capture rd_pend = 1 and rd_id = granted master.
  - Edge N+1: stage-2 captures ram_dout into the selected mi_rdata and pulses mi_rvalid for that master.
  - Fixed latency: rvalid is high in cycle N+2. Back-to-back reads are fully pipelined, one per cycle.
  - The non-selected master's rdata holds its previous value.
- Same-address write and read granted in the same cycle: the read returns the OLD contents (RAM read-before-write). Callers needing new data reissue the read.
- Reset mid-operation:
  - Pending reads in stage 1/2 are discarded; no rvalid is produced for them.
  - Pointers return to m0 priority.
  - Writes granted in the cycle rst rises are not performed (ram_wr forced 0).
- Fairness: under continuous contention on one port, grants strictly alternate m0, m1, m0, ...

Test Plan:
- Reset: hold rst 3 cycles with both reqs high -> gnt = 0, ram_wr = 0, rvalid = 0, rdata = 0 throughout; first cycle after release with contending writes -> m0 granted.
- Single write/read: m0 writes 0xBEEF to addr 0x12; next cycle m0 reads 0x12 -> m0_gnt on both; m0_rvalid two cycles after the read grant with m0_rdata = 0xBEEF; m1_rvalid stays 0.
- Contention: both masters issue writes (m0: 0x20=0x1111, m1: 0x21=0x2222) held continuously, 4 requests each -> gnt alternates m0, m1, m0, m1, ...; readback gives 0x1111 and 0x2222.
- Concurrent ports: m0 writes 0x30=0xAAAA while m1 reads 0x40 (preloaded 0x5555) in the same cycle -> both gnt = 1 that cycle; m1_rdata = 0x5555 at latency 2.
- Read-during-write same address: 0x50 holds 0x0001; m0 writes 0x50=0x0002 while m1 reads 0x50 in the same cycle -> m1_rdata = 0x0001; a reread returns 0x0002.
- Reset mid-read: m1 read granted, rst asserted the next cycle -> no m1_rvalid; after release, rptr favours m0.
